// File: rtl/ch3_bcd_scan_counter_if.sv
// Bus bundle for the BCD scan counter: control/load inputs and count/display outputs.
interface ch3_bcd_scan_counter_if;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;

  modport master (
    output en, up, clr, load, load_val,
    input  count, carry, bcd, digit_sel
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, carry, bcd, digit_sel
  );
endinterface

// File: rtl/ch3_bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled stepping and a free-running
// one-hot digit scanner feeding a seven-segment decoder.
module ch3_bcd_scan_counter #(
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ch3_bcd_scan_counter_if.slave  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [15:0]   count_reg, count_next;
  logic          carry_reg, carry_next;
  logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]    scan_idx_reg, scan_idx_next;
  logic [3:0]    digit_sel_reg, digit_sel_next;
  logic [3:0]    bcd_reg, bcd_next;

  logic [15:0]   load_sat;
  logic [15:0]   count_step;
  logic [3:0]    lim;
  logic [3:0]    chain;
  logic          tick;

  // lim marks a digit sitting at its roll-over value for the current direction;
  // a digit moves only when every lower digit is rolling over.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] lv;
      assign d       = count_reg[gi*4 +: 4];
      assign lv      = bus.load_val[gi*4 +: 4];
      assign lim[gi] = bus.up ? (d == 4'd9) : (d == 4'd0);
      if (gi == 0) begin : g_first
        assign chain[gi] = 1'b1;
      end else begin : g_rest
        assign chain[gi] = &lim[gi-1:0];
      end
      assign count_step[gi*4 +: 4] = !chain[gi] ? d :
                                     bus.up ? ((d == 4'd9) ? 4'd0 : d + 4'd1)
                                            : ((d == 4'd0) ? 4'd9 : d - 4'd1);
      assign load_sat[gi*4 +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
  endgenerate

  assign tick = bus.en && (tick_cnt_reg == TICK_LAST);

  always_comb begin
    count_next    = count_reg;
    tick_cnt_next = tick_cnt_reg;
    carry_next    = 1'b0;
    if (bus.clr) begin
      count_next    = 16'h0000;
      tick_cnt_next = '0;
    end else if (bus.load) begin
      count_next    = load_sat;
      tick_cnt_next = '0;
    end else if (bus.en) begin
      if (tick) begin
        tick_cnt_next = '0;
        count_next    = count_step;
        carry_next    = &lim;
      end else begin
        tick_cnt_next = tick_cnt_reg + TW'(1);
      end
    end
  end

  // The scanner looks ahead to the next index so select and nibble land together.
  always_comb begin
    scan_cnt_next  = scan_cnt_reg + SW'(1);
    scan_idx_next  = scan_idx_reg;
    if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_next = '0;
      scan_idx_next = scan_idx_reg + 2'd1;
    end
    digit_sel_next = 4'b0001 << scan_idx_next;
    bcd_next       = count_reg[{scan_idx_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg  <= '0;
      count_reg     <= 16'h0000;
      carry_reg     <= 1'b0;
      scan_cnt_reg  <= '0;
      scan_idx_reg  <= 2'd0;
      digit_sel_reg <= 4'b0001;
      bcd_reg       <= 4'h0;
    end else begin
      tick_cnt_reg  <= tick_cnt_next;
      count_reg     <= count_next;
      carry_reg     <= carry_next;
      scan_cnt_reg  <= scan_cnt_next;
      scan_idx_reg  <= scan_idx_next;
      digit_sel_reg <= digit_sel_next;
      bcd_reg       <= bcd_next;
    end
  end

  assign bus.count     = count_reg;
  assign bus.carry     = carry_reg;
  assign bus.digit_sel = digit_sel_reg;
  assign bus.bcd       = bcd_reg;

endmodule

// File: tb/tb_ch3_bcd_scan_counter.sv
// Scoreboard bench: driver pushes model predictions per clock, monitor pops and compares.
module tb_ch3_bcd_scan_counter;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  ch3_bcd_scan_counter_if bus ();

  ch3_bcd_scan_counter #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] count;
    logic        carry;
    logic [3:0]  sel;
    logic [3:0]  bcd;
  } exp_t;

  exp_t q[$];
  int m_cnt = 0;
  int m_pre = 0;
  int m_k   = 0;
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int pow10(input int i);
    int r = 1;
    for (int j = 0; j < i; j++) r = r * 10;
    return r;
  endfunction

  function automatic int digit(input int c, input int i);
    return (c / pow10(i)) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int c);
    logic [15:0] r = 16'h0000;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(digit(c, i));
    return r;
  endfunction

  function automatic int sat_dec(input logic [15:0] v);
    int r = 0;
    int n;
    for (int i = 0; i < 4; i++) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      r = r + n * pow10(i);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pre = 0;
    m_k   = 0;
  endtask

  // Apply inputs for the next edge, predict the state after it, then advance.
  task automatic drive(input logic en, input logic up, input logic clr,
                       input logic load, input logic [15:0] val);
    exp_t e;
    int   old;
    int   idx;
    bus.en = en; bus.up = up; bus.clr = clr; bus.load = load; bus.load_val = val;
    old     = m_cnt;
    e.carry = 1'b0;
    if (clr) begin
      m_cnt = 0; m_pre = 0;
    end else if (load) begin
      m_cnt = sat_dec(val); m_pre = 0;
    end else if (en) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre = 0;
        if (up) begin
          e.carry = (m_cnt == 9999);
          m_cnt   = (m_cnt + 1) % 10000;
        end else begin
          e.carry = (m_cnt == 0);
          m_cnt   = (m_cnt + 9999) % 10000;
        end
      end else begin
        m_pre++;
      end
    end
    m_k++;
    idx     = (m_k / SCAN_DIV) % 4;
    e.sel   = 4'(1 << idx);
    e.bcd   = 4'(digit(old, idx));
    e.count = to_bcd(m_cnt);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, bus.count, 16'h0000);
    check({tag, "_carry"}, 16'(bus.carry), 16'h0);
    check({tag, "_bcd"},   16'(bus.bcd), 16'h0);
    check({tag, "_sel"},   16'(bus.digit_sel), 16'h1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn t=%0t count=%h carry=%b sel=%b bcd=%h (exp %h %b %b %h)",
                 $time, bus.count, bus.carry, bus.digit_sel, bus.bcd,
                 e.count, e.carry, e.sel, e.bcd);
        check("count", bus.count, e.count);
        check("carry", 16'(bus.carry), 16'(e.carry));
        check("digit_sel", 16'(bus.digit_sel), 16'(e.sel));
        check("bcd", 16'(bus.bcd), 16'(e.bcd));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.en = 1'b0; bus.up = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 16'h0000;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    repeat (40) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("count_after_40", bus.count, 16'h0010);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hA5F3);
    check("load_saturate", bus.count, 16'h9593);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0567);
    check("load_beats_tick", bus.count, 16'h0567);
    check("load_beats_tick_carry", 16'(bus.carry), 16'h0);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    repeat (16) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h4321);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1 check_reset_outputs("async");
    #1 rst_n = 1'b1;
    model_reset();
    repeat (8) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 32) == 0,
            ($urandom % 16) == 0, 16'($urandom));
    end

    check("queue_drained", 16'(q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ch3_bcd_scan_counter.md
# ch3_bcd_scan_counter

Four-digit BCD up/down counter with a built-in display scanner, sitting directly upstream of the seven-segment decoder. It keeps a 0000–9999 count and drives a 4-bit BCD nibble plus a one-hot digit select. The decoder turns the nibble into segments a–g while the select enables one digit at a time. Count rate and scan rate come from internal prescalers, so the block runs from the board clock alone.

## Interface
- TICK_DIV, default 4: clock cycles per count step while EN is high (≥1).
- SCAN_DIV, default 2: clock cycles each digit stays selected (≥1).
- CLK  input  1  system clock; everything is clocked on its rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- EN  input  1  count enable; gates the tick prescaler.
- UP  input  1  1 = count up, 0 = count down; sampled on tick cycles.
- CLR  input  1  synchronous clear of the count and tick prescaler.
- LOAD  input  1  synchronous load of LOAD_VAL.
- LOAD_VAL  input  16  four BCD nibbles; [3:0] is the ones digit, [15:12] the thousands.
- COUNT  output  16  current count, packed BCD.
- CARRY  output  1  one-cycle pulse when the count wraps.
- BCD  output  4  nibble of the selected digit, fed to the segment decoder.
- DIGIT_SEL  output  4  one-hot active-high digit enable; bit 0 = ones digit.

## Operation
- Reset values (asynchronous, RST_N low):
  - COUNT=16'h0000, CARRY=0, BCD=4'h0, DIGIT_SEL=4'b0001.
  - Tick prescaler = 0, scan prescaler = 0, scan index = 0.
- Priority on each edge: CLR > LOAD > tick step.
- CLR:
  - COUNT=0000 and tick prescaler=0.
  - CARRY=0.
  - The scanner is not affected.
- LOAD:
  - COUNT takes LOAD_VAL. Any nibble >9 is stored as 9.
  - Tick prescaler=0 and CARRY=0.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 only while EN=1 and no CLR/LOAD.
  - It holds its value while EN=0.
  - A step fires on the cycle the prescaler is at TICK_DIV-1; the prescaler then returns to 0.
- Step, up: the ones digit increments. A digit at 9 becomes 0 and carries into the next digit (ripple across all four).
- Step, down: the ones digit decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Wrap: 9999→0000 when counting up, 0000→9999 when counting down.
  - CARRY=1 on exactly the cycle COUNT shows the wrapped value, otherwise 0.
- Scanner:
  - Free-running; it ignores EN, CLR and LOAD.
  - The scan prescaler counts 0..SCAN_DIV-1. At terminal count, the scan index advances 0→1→2→3→0.
  - DIGIT_SEL = 1 << index.
  - BCD = COUNT nibble[index], registered.
- Width rules:
  - COUNT never holds a nibble >9.
  - DIGIT_SEL is always exactly one-hot, including straight after reset.

## Timing
- COUNT and CARRY are registered and update on the tick edge. Count latency from EN rising is TICK_DIV edges:
  - EN sampled high at edge 1 → COUNT changes at edge TICK_DIV.
  - With TICK_DIV=1, COUNT steps every cycle that EN=1.
- BCD is registered from COUNT, so it lags a COUNT change by one cycle for the selected digit.
- DIGIT_SEL and BCD change on the same edge and always match.
- With SCAN_DIV=2, each digit is selected for 2 cycles, giving a full frame every 8 cycles.
- UP changing mid-prescale is allowed. Only the UP value sampled on the step cycle matters.
- LOAD and a terminal tick on the same cycle: LOAD wins, no step is taken, CARRY=0.
- RST_N asserted mid-count: all state goes to its reset value immediately, without waiting for CLK. On release, the first step comes TICK_DIV enabled edges later.

## Test plan
- Reset, then EN=1, UP=1, TICK_DIV=4 for 40 cycles → COUNT steps 0000→0001 at the 4th edge and reaches 0010 after 40 enabled cycles. CARRY stays 0.
- LOAD_VAL=16'h9998, UP=1, EN=1 → COUNT goes 9999 then 0000. CARRY is high for exactly the one cycle where COUNT=0000.
- LOAD_VAL=16'h0000, UP=0 → the next step gives COUNT=9999 with CARRY=1. The step after that gives 9998.
- LOAD_VAL=16'hA5F3 → COUNT=16'h9593. LOAD together with a terminal tick → COUNT=LOAD value, no step.
- COUNT held at 16'h1234, SCAN_DIV=2 → DIGIT_SEL cycles 0001, 0010, 0100, 1000, 2 cycles each. BCD shows 4, 3, 2, 1 in step with DIGIT_SEL.
- Pulse RST_N low between clock edges during counting → all outputs go to reset values before the next CLK edge. Counting resumes from 0000 after release.
